// File: rtl/layernorm_mul_arbiter.sv
// Round-robin arbiter sharing one signed x unsigned multiplier between
// NUM_REQ requesters through a 2-stage pipeline with response backpressure.
module layernorm_mul_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int A_WIDTH  = 19,
    parameter int B_WIDTH  = 12,
    parameter int P_WIDTH  = 31,
    parameter int ID_WIDTH = 2
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0]  req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0]  req_b,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [ID_WIDTH-1:0]         rsp_id,
    output logic [P_WIDTH-1:0]          rsp_p,
    output logic                        busy
);

    localparam int IW = $clog2(NUM_REQ);

    logic [ID_WIDTH-1:0] last;
    logic                adv;
    logic                hs;
    logic [NUM_REQ-1:0]  win;
    logic [ID_WIDTH-1:0] win_id;
    logic                found;
    int                  idx;
    logic [A_WIDTH-1:0]  sel_a;
    logic [B_WIDTH-1:0]  sel_b;

    logic                s1_v;
    logic [A_WIDTH-1:0]  s1_a;
    logic [B_WIDTH-1:0]  s1_b;
    logic [ID_WIDTH-1:0] s1_id;
    logic                s2_v;

    logic signed [P_WIDTH-1:0] ax;
    logic signed [P_WIDTH-1:0] bx;
    logic signed [P_WIDTH-1:0] prod;

    assign adv = !s2_v || rsp_ready;

    // Cyclic search starting just after the last winner.
    always_comb begin
        win    = '0;
        win_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last) + k;
            if (idx >= NUM_REQ)
                idx = idx - NUM_REQ;
            if (!found && req_valid[IW'(idx)]) begin
                found          = 1'b1;
                win[IW'(idx)]  = 1'b1;
                win_id         = ID_WIDTH'(idx);
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win[i]) begin
                sel_a = req_a[i*A_WIDTH +: A_WIDTH];
                sel_b = req_b[i*B_WIDTH +: B_WIDTH];
            end
        end
    end

    assign hs        = adv && found && !ap_rst;
    assign req_ready = (adv && !ap_rst) ? win : '0;

    // Zero-extend b so the signed multiply treats it as unsigned.
    assign ax   = {{(P_WIDTH-A_WIDTH){s1_a[A_WIDTH-1]}}, s1_a};
    assign bx   = {{(P_WIDTH-B_WIDTH){1'b0}}, s1_b};
    assign prod = ax * bx;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            last   <= ID_WIDTH'(NUM_REQ-1);
            s1_v   <= 1'b0;
            s1_a   <= '0;
            s1_b   <= '0;
            s1_id  <= '0;
            s2_v   <= 1'b0;
            rsp_p  <= '0;
            rsp_id <= '0;
        end else if (adv) begin
            s1_v <= hs;
            if (hs) begin
                s1_a  <= sel_a;
                s1_b  <= sel_b;
                s1_id <= win_id;
                last  <= win_id;
            end
            s2_v   <= s1_v;
            rsp_p  <= prod;
            rsp_id <= s1_id;
        end
    end

    assign rsp_valid = s2_v;
    assign busy      = s1_v || s2_v;

endmodule

// File: tb/tb_layernorm_mul_arbiter.sv
// Directed bench for layernorm_mul_arbiter: handshakes, products,
// round-robin order, backpressure and reset.
module tb_layernorm_mul_arbiter;

    logic        ap_clk;
    logic        ap_rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [75:0] req_a;
    logic [47:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [30:0] rsp_p;
    logic        busy;

    int ncmp = 0;
    int nerr = 0;

    layernorm_mul_arbiter #(
        .NUM_REQ(4), .A_WIDTH(19), .B_WIDTH(12),
        .P_WIDTH(31), .ID_WIDTH(2)
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_p(rsp_p), .busy(busy)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint pv();
        return longint'($signed(rsp_p));
    endfunction

    task automatic set_op(input int id, input int a, input int b);
        req_a[id*19 +: 19] = a[18:0];
        req_b[id*12 +: 12] = b[11:0];
    endtask

    task automatic op(input int id, input int a, input int b, input longint p);
        set_op(id, a, b);
        req_valid     = '0;
        req_valid[id] = 1'b1;
        #1;
        chk("op_ready", longint'(req_ready), longint'(1) << id);
        tick();
        req_valid = '0;
        chk("op_lat1", longint'(rsp_valid), 0);
        chk("op_busy", longint'(busy), 1);
        tick();
        chk("op_valid", longint'(rsp_valid), 1);
        chk("op_p", pv(), p);
        chk("op_id", longint'(rsp_id), id);
        tick();
        chk("op_drain", longint'(busy), 0);
    endtask

    initial begin
        ap_rst    = 1'b1;
        req_valid = 4'b1111;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        @(posedge ap_clk);
        tick();
        chk("rst_ready", longint'(req_ready), 0);
        chk("rst_valid", longint'(rsp_valid), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_p", longint'(rsp_p), 0);
        chk("rst_id", longint'(rsp_id), 0);
        ap_rst    = 1'b0;
        req_valid = '0;

        op(0, -3, 5, -15);
        op(1, -262144, 4095, -64'sd1073479680);
        op(2, 262143, 4095, 64'sd1073475585);
        op(3, 0, 4095, 0);

        for (int i = 0; i < 4; i++)
            set_op(i, i + 1, 10);
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("fair_grant", longint'(req_ready), longint'(1) << (c % 4));
            if (c >= 2) begin
                chk("fair_rid", longint'(rsp_id), (c - 2) % 4);
                chk("fair_rp", pv(), ((c - 2) % 4 + 1) * 10);
            end
            tick();
        end
        req_valid = '0;
        chk("fair_tail_id2", longint'(rsp_id), 2);
        tick();
        chk("fair_tail_id3", longint'(rsp_id), 3);
        tick();
        chk("fair_idle", longint'(rsp_valid), 0);

        set_op(1, 100, 3);
        set_op(3, -7, 2);
        req_valid = 4'b1010;
        #1;
        chk("bp_g1", longint'(req_ready), 2);
        tick();
        set_op(1, 101, 3);
        #1;
        chk("bp_g3", longint'(req_ready), 8);
        tick();
        rsp_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("bp_stall_ready", longint'(req_ready), 0);
            chk("bp_stall_valid", longint'(rsp_valid), 1);
            chk("bp_stall_id", longint'(rsp_id), 1);
            chk("bp_stall_p", pv(), 300);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_resume_grant", longint'(req_ready), 2);
        chk("bp_resume_id", longint'(rsp_id), 1);
        chk("bp_resume_p", pv(), 300);
        tick();
        req_valid = '0;
        chk("bp_r2_id", longint'(rsp_id), 3);
        chk("bp_r2_p", pv(), -14);
        tick();
        chk("bp_r3_id", longint'(rsp_id), 1);
        chk("bp_r3_p", pv(), 303);
        tick();
        chk("bp_idle", longint'(rsp_valid), 0);

        op(3, 1, 1, 1);
        req_valid = 4'b0100;
        #1;
        chk("skip_g2", longint'(req_ready), 4);
        tick();
        req_valid = 4'b1001;
        #1;
        chk("skip_g3", longint'(req_ready), 8);
        tick();
        chk("skip_g0", longint'(req_ready), 1);
        tick();
        req_valid = '0;
        tick();
        tick();
        chk("skip_idle", longint'(busy), 0);

        set_op(0, 9, 9);
        set_op(1, 4, 4);
        req_valid = 4'b0011;
        #1;
        chk("mid_g1", longint'(req_ready), 2);
        tick();
        chk("mid_g0", longint'(req_ready), 1);
        tick();
        ap_rst = 1'b1;
        #1;
        chk("mid_rst_ready", longint'(req_ready), 0);
        tick();
        ap_rst = 1'b0;
        #1;
        chk("mid_post_valid", longint'(rsp_valid), 0);
        chk("mid_post_busy", longint'(busy), 0);
        chk("mid_post_grant", longint'(req_ready), 1);
        tick();
        req_valid = '0;
        chk("mid_no_stale", longint'(rsp_valid), 0);
        tick();
        chk("mid_new_valid", longint'(rsp_valid), 1);
        chk("mid_new_id", longint'(rsp_id), 0);
        chk("mid_new_p", pv(), 81);
        tick();
        chk("mid_end_valid", longint'(rsp_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
